// File: rtl/alu_bus_if.sv
// Input-side bus bundle for the single-bus ALU: shared data bus, operation select and control strobes.
interface alu_bus_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] busIn;
  logic [2:0]       opControl;
  logic             ALUin0;
  logic             ALUin1;
  logic             ALUOutLatch;
  logic             ALUOutEn;

  modport master (
    output busIn, opControl, ALUin0, ALUin1, ALUOutLatch, ALUOutEn
  );

  modport slave (
    input busIn, opControl, ALUin0, ALUin1, ALUOutLatch, ALUOutEn
  );
endinterface

// File: rtl/alu_bus_top.sv
// Single-bus ALU datapath: operand registers A/B load from the shared bus, an eight-op ALU
// feeds result register R, and R is driven onto busOut only while output-enabled.
module alu_bus_top #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  alu_bus_if.slave         bus,
  output logic [WIDTH-1:0] busOut
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } alu_op_e;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] w_f;
  alu_op_e          w_op;

  assign w_op = alu_op_e'(bus.opControl);

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves w_f unassigned (no latch).
    w_f = '0;
    unique case (w_op)
      OP_ADD: w_f = r_a + r_b;
      OP_SUB: w_f = r_a - r_b;
      OP_AND: w_f = r_a & r_b;
      OP_OR:  w_f = r_a | r_b;
      OP_XOR: w_f = r_a ^ r_b;
      OP_NOT: w_f = ~r_a;
      OP_SHL: w_f = {r_a[WIDTH-2:0], 1'b0};
      OP_SHR: w_f = {1'b0, r_a[WIDTH-1:1]};
      default: w_f = '0;
    endcase
  end

  // NOTE: non-blocking updates make R capture F from the pre-edge A/B even when an operand
  // loads on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
    end else begin
      if (bus.ALUin0)      r_a      <= bus.busIn;
      if (bus.ALUin1)      r_b      <= bus.busIn;
      if (bus.ALUOutLatch) r_result <= w_f;
    end
  end

  // Purely combinational drive so even a sub-cycle enable pulse presents R.
  assign busOut = bus.ALUOutEn ? r_result : 'z;

endmodule

// File: tb/tb_alu_bus_top.sv
// Self-checking bench for alu_bus_top: directed test-plan vectors plus randomized traffic,
// all compared against an arithmetic reference model of A, B and R.
module tb_alu_bus_top;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst;
  wire  [WIDTH-1:0] busOut;

  alu_bus_if #(.WIDTH(WIDTH)) bus ();

  alu_bus_top #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus.slave),
    .busOut (busOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  logic [15:0] ma, mb, mr;

  function automatic logic [15:0] ref_alu(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    int ia;
    int ib;
    ia = int'(a);
    ib = int'(b);
    case (op)
      3'd0:    return 16'((ia + ib) % 65536);
      3'd1:    return 16'((ia - ib + 65536) % 65536);
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return 16'(65535 - ia);
      3'd6:    return 16'((ia * 2) % 65536);
      default: return 16'(ia / 2);
    endcase
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: inputs applied just after a rising edge, model advanced on the next edge.
  task automatic step(input logic r, input logic in0, input logic in1, input logic lat,
                      input logic en, input logic [2:0] op, input logic [15:0] din);
    logic [15:0] f_pre;
    rst             = r;
    bus.ALUin0      = in0;
    bus.ALUin1      = in1;
    bus.ALUOutLatch = lat;
    bus.ALUOutEn    = en;
    bus.opControl   = op;
    bus.busIn       = din;
    f_pre = ref_alu(op, ma, mb);
    @(posedge clk);
    if (r) begin
      ma = '0;
      mb = '0;
      mr = '0;
    end else begin
      if (lat) mr = f_pre;
      if (in0) ma = din;
      if (in1) mb = din;
    end
    #1;
  endtask

  task automatic glitch_a(input logic [15:0] din);
    bus.busIn  = din;
    #1 bus.ALUin0 = 1'b1;
    #2 bus.ALUin0 = 1'b0;
  endtask

  task automatic glitch_rst();
    #1 rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  task automatic en_pulse_check(input logic [15:0] exp);
    bus.ALUOutEn = 1'b0;
    #1 bus.ALUOutEn = 1'b1;
    #1 check("short_en_pulse", busOut, exp);
    bus.ALUOutEn = 1'b0;
  endtask

  // Every falling edge: busOut must show R when enabled and must not present R otherwise.
  always @(negedge clk) begin
    if (cmp_on) begin
      if (bus.ALUOutEn) begin
        check("bus_cycle", busOut, mr);
      end else if (mr != 16'h0000) begin
        checks++;
        if (busOut === mr) begin
          errors++;
          $display("FAIL bus_disabled: got %h while disabled, R is %h at %0t", busOut, mr, $time);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [15:0] op_exp [8];

  initial begin
    op_exp = '{16'h24FC, 16'hFF6C, 16'h1200, 16'h12FC, 16'h00FC, 16'hEDCB, 16'h2468, 16'h091A};
    ma = 'x;
    mb = 'x;
    mr = 'x;
    rst = 1'b0;
    bus.ALUin0 = 1'b0;
    bus.ALUin1 = 1'b0;
    bus.ALUOutLatch = 1'b0;
    bus.ALUOutEn = 1'b0;
    bus.opControl = 3'd0;
    bus.busIn = '0;
    @(posedge clk);
    #1;

    // Reset with every strobe high: reset must win.
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 16'hBEEF);
    cmp_on = 1'b1;
    check("reset_value", busOut, 16'h0000);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);

    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h1234);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h12C8);
    for (int op = 0; op < 8; op++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'(op), 16'h0000);
      check($sformatf("op%0d_bus", op), busOut, op_exp[op]);
      check($sformatf("op%0d_model", op), mr, op_exp[op]);
    end

    // Hold and ordering.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 16'h0000);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 16'h0001);
    check("hold_no_latch", busOut, 16'h24FC);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 16'h0002);
    check("latch_uses_old_a", busOut, 16'h12C9);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 16'h0000);
    check("new_a_after_load", busOut, 16'h12CA);

    // Wrap-around.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 16'hFFFF);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 16'h0001);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 16'h0000);
    check("add_wrap", busOut, 16'h0000);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0000);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 16'h0000);
    check("sub_wrap", busOut, 16'hFFFF);

    // Strobe pulses that miss every rising edge.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0000);
    glitch_a(16'h5555);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 16'h0000);
    check("a_glitch_ignored", busOut, 16'h0001);
    glitch_rst();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0000);
    check("rst_glitch_ignored", busOut, 16'h0001);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd6, 16'h0000);
    en_pulse_check(16'h0001);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 3) != 0), 3'($urandom), 16'($urandom));
    end

    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0000);
    cmp_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
